// File: rtl/hazard_controller_pkg.sv
// Shared types for the decode-stage hazard controller: decision encodings,
// the in-flight writer shadow slot, and the source/destination match helper.
package hazard_controller_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_FREEZE = 2'b11
  } ctrl_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

  // x0 is never a real destination, so it can never create a dependency.
  function automatic logic slot_match(
    input logic                  s_valid,
    input logic [REG_ADDR_W-1:0] s_rd,
    input logic                  uses_rs1,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  uses_rs2,
    input logic [REG_ADDR_W-1:0] rs2
  );
    return s_valid && (s_rd != '0) &&
           ((uses_rs1 && (rs1 == s_rd)) || (uses_rs2 && (rs2 == s_rd)));
  endfunction

endpackage

// File: rtl/hazard_shadow_slot.sv
// One in-flight writer record {valid, rd, is_load}; holds while the pipe
// is frozen and loads an invalid entry when cleared.
module hazard_shadow_slot
  import hazard_controller_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (!hold) begin
      q <= clear ? slot_t'('0) : d;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage pipeline sequencer: picks FREEZE/FLUSH/STALL/RUN each cycle from
// a private shadow of the EX/MEM/WB writers and keeps saturating perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter bit RF_BYPASS  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_hold,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  slot_t       ex_d, ex_q, mem_q, wb_q;
  ctrl_state_e state_reg, state_next;
  logic        match_ex, match_mem, match_wb, hazard;
  logic        unused_wb_load;

  assign ex_d = '{valid:   id_valid & id_reg_write & (id_rd != '0),
                  rd:      id_rd,
                  is_load: id_mem_read};

  hazard_shadow_slot u_slot_ex (
    .clk(clk), .reset(reset), .hold(pipe_hold), .clear(id_ex_bubble), .d(ex_d), .q(ex_q)
  );
  hazard_shadow_slot u_slot_mem (
    .clk(clk), .reset(reset), .hold(pipe_hold), .clear(1'b0), .d(ex_q), .q(mem_q)
  );
  hazard_shadow_slot u_slot_wb (
    .clk(clk), .reset(reset), .hold(pipe_hold), .clear(1'b0), .d(mem_q), .q(wb_q)
  );

  assign unused_wb_load = wb_q.is_load;

  assign match_ex  = slot_match(ex_q.valid,  ex_q.rd,  id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);
  assign match_mem = slot_match(mem_q.valid, mem_q.rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);
  assign match_wb  = slot_match(wb_q.valid,  wb_q.rd,  id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);

  always_comb begin
    hazard = 1'b0;
    if (FORWARDING) begin
      hazard = id_valid & match_ex & ex_q.is_load;
    end else begin
      hazard = id_valid & (match_ex | match_mem | (~RF_BYPASS & match_wb));
    end
  end

  // Priority FREEZE > FLUSH > STALL > RUN; everything is forced low during reset.
  always_comb begin
    state_next   = ST_RUN;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (!reset) begin
      state_next = ST_RUN;
    end else if (mem_busy) begin
      state_next = ST_FREEZE;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      // ID holds a wrong-path instruction, so any hazard it raises is moot.
      state_next   = ST_FLUSH;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      state_next   = ST_STALL;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_reg <= state_next;
      if (((state_next == ST_STALL) || (state_next == ST_FREEZE)) &&
          (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if ((state_next == ST_FLUSH) && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  assign ctrl_state = state_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: one forwarding core (a_*) and one non-forwarding core with
// RF bypass (b_*) see the same instruction stream; expectations are hand-derived.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, mem_busy;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_pipe_hold;
  logic [1:0]  a_ctrl_state;
  logic [31:0] a_stall_count, a_flush_count;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_pipe_hold;
  logic [1:0]  b_ctrl_state;
  logic [31:0] b_stall_count, b_flush_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  hazard_controller #(.FORWARDING(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
    .if_id_flush(a_if_id_flush), .id_ex_bubble(a_id_ex_bubble), .pipe_hold(a_pipe_hold),
    .ctrl_state(a_ctrl_state), .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  hazard_controller #(.FORWARDING(1'b0), .RF_BYPASS(1'b1), .CNT_W(32)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble), .pipe_hold(b_pipe_hold),
    .ctrl_state(b_ctrl_state), .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // pc_write / id_ex_bubble of both cores in one go.
  task automatic chk_ctl(input string tag, input logic pa, input logic ba,
                         input logic pb, input logic bb);
    check({tag, ".a_pc_write"},   {31'd0, a_pc_write},     {31'd0, pa});
    check({tag, ".a_bubble"},     {31'd0, a_id_ex_bubble}, {31'd0, ba});
    check({tag, ".b_pc_write"},   {31'd0, b_pc_write},     {31'd0, pb});
    check({tag, ".b_bubble"},     {31'd0, b_id_ex_bubble}, {31'd0, bb});
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic rw,
                        input logic mr, input logic [4:0] rd);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_reg_write = rw; id_mem_read = mr; id_rd = rd;
  endtask

  task automatic tick(input string what);
    @(posedge clk);
    #1;
    cyc++;
    $display("cycle %0d %-12s a_state=%0d a_stall=%0d a_flush=%0d b_state=%0d b_stall=%0d",
             cyc, what, a_ctrl_state, a_stall_count, a_flush_count, b_ctrl_state, b_stall_count);
  endtask

  initial begin
    reset = 1'b0;
    mem_busy = 1'b0;
    ex_branch_taken = 1'b1;
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5);
    #2;
    chk_ctl("reset_comb", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_comb.a_flush", {31'd0, a_if_id_flush}, 32'd0);
    check("reset_comb.a_ifid_wr", {31'd0, a_if_id_write}, 32'd0);
    tick("reset");
    check("reset.a_state", {30'd0, a_ctrl_state}, 32'd0);
    check("reset.a_stall", a_stall_count, 32'd0);
    check("reset.a_flush_cnt", a_flush_count, 32'd0);
    reset = 1'b1;
    ex_branch_taken = 1'b0;

    // lw x5 ; add x6,x5,x1
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);
    #1 chk_ctl("lw_x5", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("lw x5");
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6);
    #1 chk_ctl("ldu_stall", 1'b0, 1'b1, 1'b0, 1'b1);
    tick("add x6 st");
    check("ldu.a_state", {30'd0, a_ctrl_state}, 32'd1);
    check("ldu.a_stall", a_stall_count, 32'd1);
    #1 chk_ctl("ldu_after", 1'b1, 1'b0, 1'b0, 1'b1);
    tick("add x6");
    check("ldu_after.a_state", {30'd0, a_ctrl_state}, 32'd0);
    check("ldu_after.b_stall", b_stall_count, 32'd2);
    #1 chk_ctl("ldu_bypass", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("add x6");

    // add x5 ; sub x7,x5,x2
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5);
    #1 chk_ctl("add_x5", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("add x5");
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7);
    #1 chk_ctl("alu_dep1", 1'b1, 1'b0, 1'b0, 1'b1);
    tick("sub x7");
    #1 chk_ctl("alu_dep2", 1'b1, 1'b0, 1'b0, 1'b1);
    tick("sub x7");
    #1 chk_ctl("alu_dep3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("sub x7");
    check("alu_dep.b_stall", b_stall_count, 32'd4);
    check("alu_dep.a_stall", a_stall_count, 32'd1);
    check("alu_dep.b_state", {30'd0, b_ctrl_state}, 32'd0);

    // lw x0 ; add x1,x0,x0
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);
    #1 chk_ctl("lw_x0", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("lw x0");
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd1);
    #1 chk_ctl("x0_dep", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("add x1");
    check("x0_dep.a_stall", a_stall_count, 32'd1);

    // lw x9 ; add x3,x9,x9 with taken branch in EX
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9);
    #1 chk_ctl("lw_x9", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("lw x9");
    set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd3);
    ex_branch_taken = 1'b1;
    #1 chk_ctl("flush_ldu", 1'b1, 1'b1, 1'b1, 1'b1);
    check("flush_ldu.a_ifid_flush", {31'd0, a_if_id_flush}, 32'd1);
    check("flush_ldu.b_ifid_flush", {31'd0, b_if_id_flush}, 32'd1);
    tick("flush");
    check("flush.a_state", {30'd0, a_ctrl_state}, 32'd2);
    check("flush.a_flush_cnt", a_flush_count, 32'd1);
    check("flush.a_stall", a_stall_count, 32'd1);
    ex_branch_taken = 1'b0;
    id_valid = 1'b0;
    #1 chk_ctl("after_flush", 1'b1, 1'b0, 1'b1, 1'b0);
    check("after_flush.a_ifid_flush", {31'd0, a_if_id_flush}, 32'd0);
    tick("bubble");

    // mem_busy for 3 cycles with a taken branch waiting in EX
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("freeze.a_hold", {31'd0, a_pipe_hold}, 32'd1);
      check("freeze.a_ifid_wr", {31'd0, a_if_id_write}, 32'd0);
      check("freeze.a_ifid_flush", {31'd0, a_if_id_flush}, 32'd0);
      chk_ctl("freeze", 1'b0, 1'b0, 1'b0, 1'b0);
      tick("freeze");
      check("freeze.a_state", {30'd0, a_ctrl_state}, 32'd3);
    end
    check("freeze.a_stall", a_stall_count, 32'd4);
    mem_busy = 1'b0;
    #1 chk_ctl("freeze_flush", 1'b1, 1'b1, 1'b1, 1'b1);
    check("freeze_flush.a_hold", {31'd0, a_pipe_hold}, 32'd0);
    tick("flush");
    check("freeze_flush.a_flush_cnt", a_flush_count, 32'd2);
    check("freeze_flush.a_state", {30'd0, a_ctrl_state}, 32'd2);
    check("freeze_flush.a_stall", a_stall_count, 32'd4);
    ex_branch_taken = 1'b0;
    id_valid = 1'b0;
    tick("bubble");

    // reset asserted in the middle of a load-use stall
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);
    tick("lw x5");
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6);
    #1 check("pre_reset.a_bubble", {31'd0, a_id_ex_bubble}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_reset.a_state", {30'd0, a_ctrl_state}, 32'd0);
    check("mid_reset.a_stall", a_stall_count, 32'd0);
    check("mid_reset.a_flush_cnt", a_flush_count, 32'd0);
    tick("reset");
    check("mid_reset.b_stall", b_stall_count, 32'd0);
    reset = 1'b1;
    #1 chk_ctl("post_reset", 1'b1, 1'b0, 1'b1, 1'b0);
    tick("add x6");
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);
    tick("lw x5");
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6);
    #1 chk_ctl("post_reset_ldu", 1'b0, 1'b1, 1'b0, 1'b1);
    tick("add x6 st");
    check("post_reset_ldu.a_stall", a_stall_count, 32'd1);
    check("post_reset_ldu.a_state", {30'd0, a_ctrl_state}, 32'd1);
    #1 chk_ctl("post_reset_run", 1'b1, 1'b0, 1'b0, 1'b1);
    tick("add x6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
